// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared state enum, key count, pitch table and key priority helper
package piano_pkg;

  typedef enum logic [1:0] {IDLE, GAP, PLAY, SUSTAIN} state_e;

  localparam int NUM_KEYS = 8;

  // Half-period in 50 MHz cycles, C4 through C5
  localparam int unsigned HALF_PERIOD [NUM_KEYS] = '{
    95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778
  };

  function automatic logic [2:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period counter and toggle flip-flop producing the square wave
module tone_divider #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         restart,
  input  logic [W-1:0] half_period,
  output logic         wave
);

  logic [W-1:0] cnt;

  // Restart always begins on the high phase; disabled means silent and cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      wave <= 1'b1;
    end else if (enable) begin
      if (cnt == half_period - 1'b1) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt  <= '0;
      wave <= 1'b0;
    end
  end

endmodule

// File: rtl/piano_tone_driver.sv
// rtl/piano_tone_driver.sv - held-key tracking, note priority FSM and speaker drive; PIANO_TONE_SUSTAIN_EN adds a release tail
module piano_tone_driver #(
  parameter int NUM_KEYS       = 8,
  parameter int DIV_WIDTH      = 17,
  parameter int GAP_CYCLES     = 1000,
  parameter int SUSTAIN_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_press,
  input  logic [NUM_KEYS-1:0] key_release,
  output logic                speaker,
  output logic                active,
  output logic [2:0]          note
);
  import piano_pkg::*;

  state_e              state, nxt_state;
  logic [NUM_KEYS-1:0] held, held_nxt;
  logic [2:0]          nxt_note;
  logic [DIV_WIDTH-1:0] gap_cnt;
  logic                gap_start, gap_done, tone_restart, tone_enable;

`ifdef PIANO_TONE_SUSTAIN_EN
  localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
  logic [SUS_W-1:0] sus_cnt;
  logic             sus_done;
  assign sus_done = (sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1));
`else
  logic unused_sustain;
  assign unused_sustain = ^SUSTAIN_CYCLES;
`endif

  assign gap_done = (gap_cnt == DIV_WIDTH'(GAP_CYCLES - 1));

  // Presses always win; a release only matters when it drops the sounding note.
  always_comb begin
    held_nxt  = (held | key_press) & ~key_release;
    nxt_state = state;
    nxt_note  = note;
    gap_start = 1'b0;
    if (|key_press) begin
      gap_start = 1'b1;
      nxt_note  = lowest_set(key_press);
    end else begin
      case (state)
        GAP, PLAY: begin
          if (key_release[note]) begin
            if (|held_nxt) begin
              gap_start = 1'b1;
              nxt_note  = lowest_set(held_nxt);
            end else begin
`ifdef PIANO_TONE_SUSTAIN_EN
              nxt_state = (state == PLAY) ? SUSTAIN : IDLE;
`else
              nxt_state = IDLE;
`endif
            end
          end else if (state == GAP && gap_done) begin
            nxt_state = PLAY;
          end
        end
        SUSTAIN: begin
`ifdef PIANO_TONE_SUSTAIN_EN
          if (sus_done) nxt_state = IDLE;
`else
          nxt_state = IDLE;
`endif
        end
        default: ;
      endcase
    end
    if (gap_start) nxt_state = GAP;
  end

  assign tone_restart = (state == GAP) && (nxt_state == PLAY);
  assign tone_enable  = (nxt_state == PLAY) || (nxt_state == SUSTAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      note    <= '0;
      held    <= '0;
      active  <= 1'b0;
      gap_cnt <= '0;
`ifdef PIANO_TONE_SUSTAIN_EN
      sus_cnt <= '0;
`endif
    end else begin
      state   <= nxt_state;
      note    <= nxt_note;
      held    <= held_nxt;
      active  <= (nxt_state != IDLE);
      gap_cnt <= (state == GAP && !gap_start) ? gap_cnt + 1'b1 : '0;
`ifdef PIANO_TONE_SUSTAIN_EN
      sus_cnt <= (state == SUSTAIN) ? sus_cnt + 1'b1 : '0;
`endif
    end
  end

  tone_divider #(.W(DIV_WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (tone_enable),
    .restart    (tone_restart),
    .half_period(DIV_WIDTH'(HALF_PERIOD[note])),
    .wave       (speaker)
  );

endmodule

// File: tb/tb_piano_tone_driver.sv
// tb/tb_piano_tone_driver.sv - scoreboard bench for piano_tone_driver with a time-based reference model
module tb_piano_tone_driver;

  localparam int GAP = 4;
  localparam int SUS = 100;
  localparam int HP [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] key_press = '0;
  logic [7:0] key_release = '0;
  logic       speaker, active;
  logic [2:0] note;

  piano_tone_driver #(
    .NUM_KEYS(8), .DIV_WIDTH(17), .GAP_CYCLES(GAP), .SUSTAIN_CYCLES(SUS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_press(key_press), .key_release(key_release),
    .speaker(speaker), .active(active), .note(note)
  );

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  bit         mon_en = 1'b0;
  logic [4:0] last_exp = '0;
  logic [4:0] seen = '0;
  logic [4:0] mon_cur;
  ev_t        mon_ev;

  // Model: 0 silent, 1 sounding (gap then tone from m_start), 2 release tail
  int         m_mode = 0;
  int         m_note = 0;
  int         m_start = 0;
  int         m_tail_end = 0;
  logic [7:0] m_held = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] model_out(input int e);
    logic spk;
    spk = 1'b0;
    if (m_mode != 0 && e >= m_start) spk = (((e - m_start) / HP[m_note]) % 2) == 0;
    return {spk, (m_mode != 0), 3'(m_note)};
  endfunction

  task automatic model_edge(input int e, input logic [7:0] p, input logic [7:0] r);
    logic [7:0] hn;
    hn = (m_held | p) & ~r;
    if (m_mode == 2 && e >= m_tail_end) m_mode = 0;
    if (p != 0) begin
      m_note  = lowest(p);
      m_mode  = 1;
      m_start = e + GAP;
    end else if (m_mode == 1 && r[m_note]) begin
      if (hn != 0) begin
        m_note  = lowest(hn);
        m_start = e + GAP;
      end
`ifdef PIANO_TONE_SUSTAIN_EN
      else if (e > m_start) begin
        m_mode     = 2;
        m_tail_end = e + SUS;
      end
`endif
      else m_mode = 0;
    end
    m_held = hn;
  endtask

  task automatic emit(input int e);
    logic [4:0] v;
    v = model_out(e);
    if (v !== last_exp) begin
      exp_q.push_back('{e, v});
      last_exp = v;
    end
  endtask

  task automatic cycle(input logic [7:0] p, input logic [7:0] r);
    int e;
    e = cyc + 1;
    key_press   = p;
    key_release = r;
    model_edge(e, p, r);
    emit(e);
    @(posedge clk);
    #1;
    key_press   = '0;
    key_release = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {speaker, active, note};
      if (mon_cur !== seen) begin
        seen = mon_cur;
        chk("event_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_ev = exp_q.pop_front();
          chk("event_cycle", cyc, mon_ev.cyc);
          chk("event_outputs", int'(mon_cur), int'(mon_ev.val));
        end
      end
    end
  end

  initial begin
    logic [7:0] p, rl;
    int r;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_speaker", int'(speaker), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_note", int'(note), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // single key 5: gap, full high half-period, into low phase, release
    cycle(8'h20, 8'h00); idle(GAP + HP[5] + 40);
    cycle(8'h00, 8'h20); idle(10);

    // priority and fallback
    cycle(8'h44, 8'h00); idle(20);
    cycle(8'h80, 8'h00); idle(20);
    cycle(8'h00, 8'h80); idle(20);
    cycle(8'h00, 8'h40); idle(20);
    cycle(8'h00, 8'h04); idle(10);

    // same-cycle press and release of key 3 while idle
    cycle(8'h08, 8'h08); idle(20);
    cycle(8'h00, 8'h20); idle(10);
    cycle(8'h00, 8'h08); idle(10);

    // retrigger key 0
    cycle(8'h01, 8'h00); idle(30);
    cycle(8'h01, 8'h00); idle(30);
    cycle(8'h00, 8'h01); idle(5);

    // last release, then press during any tail
    cycle(8'h10, 8'h00); idle(10);
    cycle(8'h00, 8'h10); idle(SUS + 20);
    cycle(8'h10, 8'h00); idle(10);
    cycle(8'h00, 8'h10); idle(30);
    cycle(8'h40, 8'h00); idle(10);
    cycle(8'h00, 8'h40); idle(SUS + 10);

    // randomized key traffic
    repeat (500) begin
      r  = $urandom_range(0, 9);
      p  = '0;
      rl = '0;
      if (r == 0) p = 8'(1 << $urandom_range(0, 7));
      if (r == 1) p = 8'($urandom_range(1, 255));
      if (r == 2 || r == 3) rl = 8'(1 << $urandom_range(0, 7));
      if (r == 4) begin
        p  = 8'(1 << $urandom_range(0, 7));
        rl = p;
      end
      cycle(p, rl);
    end
    idle(20);

    // asynchronous reset in the middle of a note
    cycle(8'h02, 8'h00); idle(GAP + 6);
    #2;
    m_mode = 0; m_note = 0; m_held = '0;
    emit(cyc);
    rst_n = 1'b0;
    #1;
    chk("midnote_reset_speaker", int'(speaker), 0);
    chk("midnote_reset_active", int'(active), 0);
    chk("midnote_reset_note", int'(note), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    cycle(8'h80, 8'h00); idle(GAP + 3);
    cycle(8'h00, 8'h80); idle(3);

    repeat (2) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
